// File: rtl/popcnt_pkg.sv
// Shared definitions for the sequenced population counter.
// Contents: FSM state encoding, a constant clog2, and helpers that derive the
// chunk count and result width from the word width and chunk size.
package popcnt_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(value)) res = i + 1;
    end
    return res;
  endfunction

  // Number of CHUNK-bit slices needed to cover a W-bit word.
  function automatic int unsigned nchunk(input int unsigned w, input int unsigned chunk);
    return (w + chunk - 1) / chunk;
  endfunction

  // Width that holds any count from 0 to W inclusive.
  function automatic int unsigned out_w(input int unsigned w);
    return clog2(w + 1);
  endfunction

endpackage

// File: rtl/popcnt_chunk.sv
// Combinational popcount of one CHUNK-bit slice.
// Ports:
//   data_i  - slice to count
//   count_o - number of set bits in data_i, clog2(CHUNK+1) bits wide
module popcnt_chunk
  import popcnt_pkg::*;
#(
  parameter int unsigned CHUNK = 16,
  localparam int unsigned SUM_W = clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] data_i,
  output logic [SUM_W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      count_o = count_o + SUM_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/popcnt_ctrl.sv
// Sequenced population counter: accepts a W-bit word over valid/ready, counts
// CHUNK bits per cycle through one shared chunk counter, and returns the count
// over a second valid/ready handshake.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   in_data/in_valid/in_ready - word input handshake
//   clr                      - synchronous abort, highest priority
//   out_count/out_valid/out_ready - result output handshake
//   busy                     - high while a word is being counted or held
module popcnt_ctrl
  import popcnt_pkg::*;
#(
  parameter int unsigned W = 255,
  parameter int unsigned CHUNK = 16,
  localparam int unsigned NCHUNK = nchunk(W, CHUNK),
  localparam int unsigned OUT_W = out_w(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  output logic [OUT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned SH_W  = NCHUNK * CHUNK;
  localparam int unsigned SUM_W = clog2(CHUNK + 1);
  localparam int unsigned IDX_W = (NCHUNK > 1) ? clog2(NCHUNK) : 1;

  state_e             state_q, state_d;
  logic [SH_W-1:0]    sh_q, sh_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SUM_W-1:0]   chunk_sum;

  popcnt_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .data_i  (sh_q[CHUNK-1:0]),
    .count_o (chunk_sum)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    if (clr) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            // Upper padding bits are zero so a partial last chunk counts correctly.
            sh_d    = SH_W'(in_data);
            acc_d   = '0;
            idx_d   = '0;
            state_d = StRun;
          end
        end
        StRun: begin
          acc_d = acc_q + OUT_W'(chunk_sum);
          sh_d  = sh_q >> CHUNK;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NCHUNK - 1)) state_d = StDone;
        end
        StDone: begin
          if (out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sh_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs depend on registered state only.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    out_count = out_valid ? acc_q : '0;
  end

endmodule

// File: tb/tb_popcnt_ctrl.sv
module tb_popcnt_ctrl;

  localparam int W  = 255;
  localparam int N0 = 16;  // chunk count at CHUNK = 16
  localparam int N1 = 1;   // chunk count at CHUNK = 255

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         clr = 1'b0;
  logic         out_ready = 1'b0;

  logic [7:0] cnt0, cnt1;
  logic       ir0, ov0, bz0, ir1, ov1, bz1;

  int checks = 0;
  int failures = 0;

  popcnt_ctrl #(
    .W     (W),
    .CHUNK (16)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (ir0),
    .clr       (clr),
    .out_count (cnt0),
    .out_valid (ov0),
    .out_ready (out_ready),
    .busy      (bz0)
  );

  popcnt_ctrl #(
    .W     (W),
    .CHUNK (255)
  ) u_dut_single (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (ir1),
    .clr       (clr),
    .out_count (cnt1),
    .out_valid (ov1),
    .out_ready (out_ready),
    .busy      (bz1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a word is either absent, counting down its
  // latency, or holding its result until the consumer takes it.
  typedef struct {
    bit busy;
    bit done;
    int left;
    int cnt;
  } mdl_t;

  mdl_t m0 = '{busy: 1'b0, done: 1'b0, left: 0, cnt: 0};
  mdl_t m1 = '{busy: 1'b0, done: 1'b0, left: 0, cnt: 0};

  function automatic mdl_t step(input mdl_t m, input int n, input bit r, input bit c,
                                input bit iv, input bit ordy, input logic [W-1:0] d);
    mdl_t s;
    s = m;
    if (r || c) begin
      s.busy = 1'b0;
      s.done = 1'b0;
    end else if (!m.busy) begin
      if (iv) begin
        s.busy = 1'b1;
        s.done = 1'b0;
        s.left = n;
        s.cnt  = $countones(d);
      end
    end else if (!m.done) begin
      s.left = m.left - 1;
      if (s.left == 0) s.done = 1'b1;
    end else if (ordy) begin
      s.busy = 1'b0;
      s.done = 1'b0;
    end
    return s;
  endfunction

  always @(posedge clk) begin
    m0 <= step(m0, N0, rst, clr, in_valid, out_ready, in_data);
    m1 <= step(m1, N1, rst, clr, in_valid, out_ready, in_data);
  end

  always @(negedge clk) begin
    chk("in_ready", ir0, !m0.busy);
    chk("busy", bz0, m0.busy);
    chk("out_valid", ov0, m0.done);
    if (m0.done) chk("out_count", cnt0, m0.cnt);
    chk("single_in_ready", ir1, !m1.busy);
    chk("single_busy", bz1, m1.busy);
    chk("single_out_valid", ov1, m1.done);
    if (m1.done) chk("single_out_count", cnt1, m1.cnt);
  end

  function automatic logic [W-1:0] rand_word(input int mode);
    logic [255:0] a, b, c;
    for (int k = 0; k < 8; k++) begin
      a[k*32 +: 32] = $urandom;
      b[k*32 +: 32] = $urandom;
      c[k*32 +: 32] = $urandom;
    end
    case (mode)
      0:       return a[W-1:0];
      1:       return a[W-1:0] & b[W-1:0] & c[W-1:0];
      2:       return a[W-1:0] | b[W-1:0] | c[W-1:0];
      3:       return '0;
      default: return '1;
    endcase
  endfunction

  // Sends one word, waits for its result, holds out_ready low for `hold`
  // cycles of DONE, then completes the output handshake.
  task automatic run_word(input logic [W-1:0] d, input int hold, input bit keep_valid,
                          output logic [7:0] got, output int lat, output int bcyc,
                          output logic [7:0] got1, output int lat1);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ir0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_send", ir0, 1);
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);  // accept at the preceding edge
    if (!keep_valid) in_valid = 1'b0;
    lat  = 0;
    lat1 = -1;
    bcyc = 0;
    got1 = '0;
    if (bz0) bcyc++;
    if (ov1) begin
      lat1 = 0;
      got1 = cnt1;
    end
    while (!ov0 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bz0) bcyc++;
      if (ov1 && lat1 < 0) begin
        lat1 = lat;
        got1 = cnt1;
      end
    end
    got = cnt0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bz0) bcyc++;
      chk("hold_in_ready", ir0, 0);
      chk("hold_out_valid", ov0, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ready_after_handshake", ir0, 1);
    chk("idle_after_handshake", bz0, 0);
  endtask

  initial begin
    logic [7:0]   got, got1;
    int           lat, lat1, bcyc, guard;
    logic [W-1:0] w;

    repeat (3) @(negedge clk);
    chk("reset_in_ready", ir0, 1);
    chk("reset_out_valid", ov0, 0);
    chk("reset_out_count", cnt0, 0);
    chk("reset_busy", bz0, 0);
    rst = 1'b0;

    run_word('0, 0, 1'b0, got, lat, bcyc, got1, lat1);
    chk("zero_count", got, 0);
    chk("zero_latency", lat, 16);
    chk("zero_busy_cycles", bcyc, 17);
    chk("single_latency", lat1, 1);
    chk("single_zero_count", got1, 0);

    run_word('1, 0, 1'b0, got, lat, bcyc, got1, lat1);
    chk("ones_count", got, 255);
    chk("single_ones_count", got1, 255);

    w = '0;
    w[254] = 1'b1;
    run_word(w, 0, 1'b0, got, lat, bcyc, got1, lat1);
    chk("top_bit_count", got, 1);

    w = '0;
    for (int i = 0; i < W; i += 2) w[i] = 1'b1;
    run_word(w, 0, 1'b0, got, lat, bcyc, got1, lat1);
    chk("alt_count", got, 128);
    chk("single_alt_count", got1, 128);

    // Backpressure with in_valid held high throughout.
    w = rand_word(0);
    run_word(w, 5, 1'b1, got, lat, bcyc, got1, lat1);
    chk("bp_count", got, $countones(w));
    @(negedge clk);
    chk("bp_reaccept", bz0, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (bz0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_drain", bz0, 0);
    out_ready = 1'b0;

    // Abort at RUN cycle 7.
    in_data  = '1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("abort_idle", ir0, 1);
    chk("abort_no_valid", ov0, 0);
    repeat (20) @(negedge clk);
    w = '0;
    w[7:0] = 8'hFF;
    run_word(w, 0, 1'b0, got, lat, bcyc, got1, lat1);
    chk("after_abort_count", got, 8);

    // Asynchronous reset mid-RUN.
    in_data  = rand_word(2);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_in_ready", ir0, 1);
    chk("async_rst_out_valid", ov0, 0);
    chk("async_rst_out_count", cnt0, 0);
    chk("async_rst_busy", bz0, 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Randomized traffic with backpressure, gaps and rare aborts.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_data   = rand_word($urandom_range(0, 4));
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 59) == 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/popcnt_ctrl.md
# popcnt_ctrl

Sequenced population counter for a 255-bit input word. It accepts a word over a valid/ready handshake and counts its set bits CHUNK bits per cycle through one shared chunk counter. It returns the 8-bit count over a second valid/ready handshake. It replaces a flat 255-input adder tree in designs where area matters more than latency, and it sits between a word producer and any consumer of bit counts.

## Interface
Parameters:
- W, default 255: input word width.
- CHUNK, default 16: bits counted per cycle; must satisfy 1 ≤ CHUNK ≤ W.
- NCHUNK, derived as ceil(W/CHUNK): 16 at the defaults.
- OUT_W, derived as clog2(W+1): 8 at the defaults.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_data, input, W: word to count.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block can accept a word.
- clr, input, 1: synchronous abort of the current operation.
- out_count, output, OUT_W: number of ones in the accepted word.
- out_valid, output, 1: out_count is valid.
- out_ready, input, 1: consumer accepts out_count.
- busy, output, 1: high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- In IDLE:
  - in_ready = 1.
  - On in_valid & ~clr: latch in_data into shift register sh, zero-padded to NCHUNK*CHUNK bits.
  - Same accept: clear acc, set idx = 0, go to RUN.
- In RUN, each cycle:
  - acc ← acc + popcount(sh[CHUNK-1:0]).
  - sh ← sh >> CHUNK.
  - idx ← idx + 1.
  - When idx == NCHUNK-1, the update is applied and the state goes to DONE.
- In DONE:
  - out_valid = 1 and out_count = acc.
  - On out_ready, go to IDLE.
- clr has priority over every other event:
  - In any state, clr returns the block to IDLE next edge and drops out_valid.
  - In IDLE, clr blocks acceptance even if in_valid = 1.
- Width rules:
  - acc is OUT_W bits and cannot overflow, since the maximum is W.
  - The chunk sum is clog2(CHUNK+1) bits, zero-extended before the add.
  - Padding bits are always 0, so a partial last chunk counts correctly.
- Outputs are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_count = 0, busy = 0, acc = 0, idx = 0, sh = 0.
- Reset asserted mid-operation aborts the operation immediately and asynchronously, leaving no residue.
- Accept occurs at edge E0. RUN lasts for edges E1..E_NCHUNK. out_valid is high from edge E_NCHUNK.
  - Latency is NCHUNK cycles from accept to result: 16 at the defaults.
  - With CHUNK = W: 1 cycle.
- out_count stays stable while out_valid = 1 & out_ready = 0, for unbounded backpressure.
- After the output handshake at edge Ek, in_ready = 1 from Ek.
  - The earliest next accept is edge Ek+1.
  - Throughput is one word per NCHUNK+2 cycles.
- in_ready = 0 throughout RUN and DONE. in_valid during those states is ignored and the data is not latched.

## Structure
- Shared package popcnt_pkg contains:
  - State encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - A clog2 constant function.
  - NCHUNK and OUT_W derivation helpers.
- Sub-module popcnt_chunk: purely combinational popcount of a CHUNK-bit slice, with output width clog2(CHUNK+1). One instance only.
- Top level holds the FSM, sh, acc and idx.

## Test plan
- Reset, then in_data = 0 accepted: out_valid rises 16 cycles after accept with out_count = 0; busy is high for exactly 17 cycles.
- in_data all ones: out_count = 255.
- in_data = 1<<254 (last, partial chunk only): out_count = 1. in_data = 0x5555…5 (bit 254 = 1): out_count = 128.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 5 cycles in DONE, with in_valid = 1 the whole time.
  - Response: out_count is held, in_ready = 0, and there is no second accept until the cycle after the output handshake.
- Abort:
  - Stimulus: pulse clr at RUN cycle 7, then submit 0xFF.
  - Response: IDLE on the next edge and out_valid is never asserted for the aborted word; the next result is out_count = 8.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously mid-RUN.
  - Response: all outputs return to their reset values before the next clk edge.
- Single-cycle configuration: CHUNK = 255 gives a 1-cycle latency with an identical count.
